mem_arbiter_ctrl: RTL and testbench
===================================

MEM_ARBITER_CTRL -- requirements
Module: mem_arbiter_ctrl

Interface
REQ-001 SHALL have parameter TIMEOUT_CYCLES, default 15, meaning the number of WAIT cycles without m_mfc before abort (used only with MEM_TIMEOUT_EN).
REQ-002 SHALL have port clk  in  1  single clock; all state changes on posedge clk.
REQ-003 SHALL have port clr  in  1  reset; synchronous, active-low.
REQ-004 SHALL have port f_req  in  1  fetch request, level; held until f_done or f_err.
REQ-005 SHALL have port f_addr  in  32  fetch address; fetch is always a word read.
REQ-006 SHALL have ports f_done, f_err  out  1 each  one-cycle completion and error pulses for the fetch port.
REQ-007 SHALL have port d_req  in  1  data request, level; held until d_done or d_err.
REQ-008 SHALL have port d_rw  in  1  data direction: 1 = read, 0 = write.
REQ-009 SHALL have port d_mas  in  2  data access size: 00 byte, 01 halfword, 10 word; 11 is illegal.
REQ-010 SHALL have ports d_addr, d_wdata  in  32 each  data address and write data.
REQ-011 SHALL have ports d_done, d_err  out  1 each  one-cycle completion and error pulses for the data port.
REQ-012 SHALL have port rdata  out  32  read data, valid in the done cycle and held until the next read completes.
REQ-013 SHALL have ports m_mfa, m_rw, m_mas, m_addr, m_wdata  out  1/1/2/32/32  registered memory-side command signals.
REQ-014 SHALL have ports m_mfc, m_rdata  in  1/32  memory function complete and memory read data.

Function
REQ-015 SHALL implement states IDLE, WAIT, DONE, ERR; requests are sampled only in IDLE.
REQ-016 IDLE with exactly one request pending SHALL grant that requester.
REQ-017 IDLE with both requests pending SHALL grant the requester not granted last (round-robin); last_grant updates on every grant.
REQ-018 A misaligned grant (halfword with addr[0]=1, word with addr[1:0]!=0) or d_mas=11 SHALL go IDLE->ERR without asserting m_mfa.
REQ-019 A legal grant SHALL go IDLE->WAIT, registering m_addr, m_rw, m_mas and m_wdata and driving m_mfa=1 from the first WAIT cycle.
REQ-020 In WAIT, m_mfa and the command signals SHALL stay stable until m_mfc=1 is sampled; the transition is then WAIT->DONE.
REQ-021 On that transition a read SHALL latch m_rdata into rdata; a write SHALL leave rdata unchanged.
REQ-022 DONE SHALL last one cycle with m_mfa=0 and the granted port's done pulse high, then return to IDLE.
REQ-023 ERR SHALL last one cycle with m_mfa=0 and the granted port's err pulse high, then return to IDLE.
REQ-024 Latency: req high in cycle 0 gives m_mfa high in cycle 1; m_mfc high in cycle k gives done in cycle k+1 (minimum k=1).
REQ-025 m_mfc SHALL be ignored outside WAIT.
REQ-026 A request that drops before completion SHALL NOT abort the access.
REQ-027 done and err SHALL never be high together, and never high for both ports in the same cycle.

Reset
REQ-028 clr=0 at posedge SHALL force IDLE, all outputs to 0, rdata to 0, last_grant to data (so fetch wins the first tie), and the timeout counter to 0.
REQ-029 Reset during WAIT SHALL drop m_mfa at that edge with no done or err pulse.

Configuration
REQ-030 With MEM_TIMEOUT_EN defined, a counter SHALL count WAIT cycles.
REQ-031 With MEM_TIMEOUT_EN defined, reaching TIMEOUT_CYCLES without m_mfc SHALL go WAIT->ERR; m_mfc in that same cycle wins and goes to DONE.
REQ-032 Without MEM_TIMEOUT_EN, WAIT SHALL wait indefinitely and err SHALL arise only from REQ-018.

Structure
REQ-033 A shared package mem_ctrl_pkg SHALL hold the state enum, the MAS encodings (MAS_BYTE, MAS_HALF, MAS_WORD) and the grant encoding (GNT_FETCH, GNT_DATA).
REQ-034 The alignment/legality check SHALL be a sub-module mem_align_chk (inputs addr[1:0] and mas; output misaligned).

Verification
REQ-035 Fetch f_addr=0x100, m_rdata=0xE3A00001, m_mfc high in cycle 3 -> m_mfa high cycles 1-3; f_done and rdata=0xE3A00001 in cycle 4.
REQ-036 f_req and d_req both high in cycle 0 after reset -> fetch granted first; after f_done, data granted next (round-robin).
REQ-037 d_rw=0, d_mas=01, d_addr=0x203 -> d_err pulse in cycle 1; m_mfa never high.
REQ-038 Data word write d_addr=0x40, d_wdata=0xDEADBEEF -> m_addr=0x40, m_wdata=0xDEADBEEF, m_rw=0 while m_mfa=1; d_done after m_mfc; rdata unchanged.
REQ-039 MEM_TIMEOUT_EN, TIMEOUT_CYCLES=4, m_mfc held low -> after 4 WAIT cycles, ERR with err pulse and m_mfa=0; without the macro, m_mfa stays high.
REQ-040 clr=0 in the second WAIT cycle -> next cycle IDLE, m_mfa=0, no done or err; the following tie grants fetch.

Source files
------------

// File: rtl/mem_ctrl_pkg.sv
// mem_ctrl_pkg -- shared definitions for the memory arbiter controller.
//   state_t   : controller states IDLE / WAIT / DONE / ERR
//   gnt_t     : which requester owns the current access (fetch or data)
//   MAS_*     : memory access size encodings carried on d_mas / m_mas
//   mem_cmd_t : the memory-side command captured on a legal grant
package mem_ctrl_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    WAIT = 2'b01,
    DONE = 2'b10,
    ERR  = 2'b11
  } state_t;

  typedef enum logic {
    GNT_FETCH = 1'b0,
    GNT_DATA  = 1'b1
  } gnt_t;

  localparam logic [1:0] MAS_BYTE = 2'b00;
  localparam logic [1:0] MAS_HALF = 2'b01;
  localparam logic [1:0] MAS_WORD = 2'b10;

  typedef struct packed {
    logic        rw;     // 1 = read, 0 = write
    logic [1:0]  mas;
    logic [31:0] addr;
    logic [31:0] wdata;
  } mem_cmd_t;

endpackage

// File: rtl/mem_align_chk.sv
// mem_align_chk -- legality check for a memory access.
//   addr[1:0]  in  low address bits of the access
//   mas        in  access size (MAS_BYTE / MAS_HALF / MAS_WORD; 2'b11 is illegal)
//   misaligned out 1 when the access may not be issued to memory
module mem_align_chk
  import mem_ctrl_pkg::*;
(
  input  logic [1:0] addr,
  input  logic [1:0] mas,
  output logic       misaligned
);

  always_comb begin
    // NOTE: assign a default before the case so no path leaves the output unassigned (no latch).
    misaligned = 1'b0;
    case (mas)
      MAS_BYTE: misaligned = 1'b0;
      MAS_HALF: misaligned = addr[0];
      MAS_WORD: misaligned = (addr != 2'b00);
      default:  misaligned = 1'b1;
    endcase
  end

endmodule

// File: rtl/mem_arbiter_ctrl.sv
// mem_arbiter_ctrl -- two-port (fetch / data) round-robin arbiter in front of a
// single handshaked memory port.
//   clk                         in   single clock, all state changes on posedge
//   clr                         in   synchronous active-low reset
//   f_req, f_addr               in   fetch request (level) and word address
//   f_done, f_err               out  one-cycle completion / error pulses, fetch port
//   d_req, d_rw, d_mas          in   data request (level), direction (1 = read), size
//   d_addr, d_wdata             in   data address and write data
//   d_done, d_err               out  one-cycle completion / error pulses, data port
//   rdata                       out  data of the last completed read
//   m_mfa, m_rw, m_mas,
//   m_addr, m_wdata             out  memory command, stable while m_mfa = 1
//   m_mfc, m_rdata              in   memory function complete and read data
// Optional feature: define MEM_TIMEOUT_EN to abort a WAIT that sees no m_mfc
// within TIMEOUT_CYCLES cycles (the access then ends in ERR).
module mem_arbiter_ctrl
  import mem_ctrl_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 15
) (
  input  logic        clk,
  input  logic        clr,
  input  logic        f_req,
  input  logic [31:0] f_addr,
  output logic        f_done,
  output logic        f_err,
  input  logic        d_req,
  input  logic        d_rw,
  input  logic [1:0]  d_mas,
  input  logic [31:0] d_addr,
  input  logic [31:0] d_wdata,
  output logic        d_done,
  output logic        d_err,
  output logic [31:0] rdata,
  output logic        m_mfa,
  output logic        m_rw,
  output logic [1:0]  m_mas,
  output logic [31:0] m_addr,
  output logic [31:0] m_wdata,
  input  logic        m_mfc,
  input  logic [31:0] m_rdata
);

  state_t   state;
  state_t   state_nxt;
  gnt_t     last_grant;   // requester granted most recently; loses the next tie
  gnt_t     grant;        // owner of the access in flight
  gnt_t     gnt_sel;
  logic     gnt_valid;
  mem_cmd_t cmd_sel;
  mem_cmd_t cmd;
  logic     misaligned;
  logic     timeout_hit;

  // Arbitration: a lone requester wins; on a tie the one not granted last wins.
  // Fetch is always a word read.
  always_comb begin
    gnt_valid = f_req | d_req;
    gnt_sel   = GNT_FETCH;
    if (f_req && d_req) begin
      gnt_sel = (last_grant == GNT_DATA) ? GNT_FETCH : GNT_DATA;
    end else if (d_req) begin
      gnt_sel = GNT_DATA;
    end
    cmd_sel = '{rw: 1'b1, mas: MAS_WORD, addr: f_addr, wdata: 32'h0};
    if (gnt_sel == GNT_DATA) begin
      cmd_sel = '{rw: d_rw, mas: d_mas, addr: d_addr, wdata: d_wdata};
    end
  end

  mem_align_chk u_align_chk (
    .addr       (cmd_sel.addr[1:0]),
    .mas        (cmd_sel.mas),
    .misaligned (misaligned)
  );

`ifdef MEM_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);

  logic [CNT_W-1:0] wait_cnt;

  // Counts completed WAIT cycles; cleared whenever the controller is not waiting.
  always_ff @(posedge clk) begin
    if (!clr) begin
      wait_cnt <= '0;
    end else if (state != WAIT) begin
      wait_cnt <= '0;
    end else if (!m_mfc && !timeout_hit) begin
      wait_cnt <= wait_cnt + CNT_W'(1);
    end
  end

  // Fires in the TIMEOUT_CYCLES-th WAIT cycle; m_mfc in that cycle still wins.
  assign timeout_hit = (state == WAIT) && (wait_cnt == CNT_W'(TIMEOUT_CYCLES - 1));
`else
  // Without the timeout feature WAIT never gives up. The always-false term keeps
  // the parameter referenced in this build.
  assign timeout_hit = (TIMEOUT_CYCLES < 0);
`endif

  // State register.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    if (!clr) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state logic. Requests are only looked at in IDLE; m_mfc only in WAIT.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (gnt_valid) begin
          state_nxt = misaligned ? ERR : WAIT;
        end
      end
      WAIT: begin
        if (m_mfc) begin
          state_nxt = DONE;
        end else if (timeout_hit) begin
          state_nxt = ERR;
        end
      end
      DONE:    state_nxt = IDLE;
      ERR:     state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Grant bookkeeping, command capture and read-data capture. The command is
  // captured only for legal grants, so it stays stable for the whole WAIT
  // even if the requester drops or changes its inputs.
  always_ff @(posedge clk) begin
    if (!clr) begin
      grant      <= GNT_FETCH;
      last_grant <= GNT_DATA;
      cmd        <= '0;
      rdata      <= '0;
    end else begin
      if (state == IDLE && gnt_valid) begin
        grant      <= gnt_sel;
        last_grant <= gnt_sel;
        if (!misaligned) begin
          cmd <= cmd_sel;
        end
      end
      if (state == WAIT && m_mfc && cmd.rw) begin
        rdata <= m_rdata;
      end
    end
  end

  // Outputs are decoded from registered state only, so no input reaches an
  // output combinationally.
  always_comb begin
    m_mfa  = 1'b0;
    f_done = 1'b0;
    f_err  = 1'b0;
    d_done = 1'b0;
    d_err  = 1'b0;
    case (state)
      WAIT: m_mfa = 1'b1;
      DONE: begin
        if (grant == GNT_FETCH) f_done = 1'b1;
        else                    d_done = 1'b1;
      end
      ERR: begin
        if (grant == GNT_FETCH) f_err = 1'b1;
        else                    d_err = 1'b1;
      end
      default: ;
    endcase
  end

  assign m_rw    = cmd.rw;
  assign m_mas   = cmd.mas;
  assign m_addr  = cmd.addr;
  assign m_wdata = cmd.wdata;

endmodule

// File: tb/tb_mem_arbiter_ctrl.sv
// tb_mem_arbiter_ctrl -- directed, self-checking bench for mem_arbiter_ctrl.
// Each access is planned on an absolute cycle timeline from the interface
// rules (grant in cycle c, m_mfa for cycles c+1..c+k, done in k+1, err in c+1
// for an illegal access, round-robin on ties). The plan fills per-cycle
// stimulus and expectation tables; one process drives the stimulus, one
// compares every output on every cycle. A few literal values pin the plan.
// Builds with or without MEM_TIMEOUT_EN.
module tb_mem_arbiter_ctrl;
  import mem_ctrl_pkg::*;

  localparam int TO  = 4;
  localparam int NC  = 128;
  localparam int P_F = 0;
  localparam int P_D = 1;

  logic        clk = 1'b0;
  logic        clr;
  logic        f_req, f_done, f_err;
  logic [31:0] f_addr;
  logic        d_req, d_rw, d_done, d_err;
  logic [1:0]  d_mas;
  logic [31:0] d_addr, d_wdata, rdata;
  logic        m_mfa, m_rw, m_mfc;
  logic [1:0]  m_mas;
  logic [31:0] m_addr, m_wdata, m_rdata;

  always #5 clk = ~clk;

  mem_arbiter_ctrl #(.TIMEOUT_CYCLES(TO)) dut (
    .clk(clk), .clr(clr),
    .f_req(f_req), .f_addr(f_addr), .f_done(f_done), .f_err(f_err),
    .d_req(d_req), .d_rw(d_rw), .d_mas(d_mas), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_done(d_done), .d_err(d_err), .rdata(rdata),
    .m_mfa(m_mfa), .m_rw(m_rw), .m_mas(m_mas), .m_addr(m_addr), .m_wdata(m_wdata),
    .m_mfc(m_mfc), .m_rdata(m_rdata)
  );

  // Stimulus table.
  logic        s_clr[NC], s_freq[NC], s_dreq[NC], s_drw[NC], s_mfc[NC];
  logic [1:0]  s_dmas[NC];
  logic [31:0] s_faddr[NC], s_daddr[NC], s_dwdata[NC], s_mrdata[NC];
  // Expectation table.
  logic        x_mfa[NC], x_fdone[NC], x_ferr[NC], x_ddone[NC], x_derr[NC];
  logic        x_cmd[NC], x_wchk[NC], x_rw[NC];
  logic [1:0]  x_mas[NC];
  logic [31:0] x_addr[NC], x_wdata[NC], x_rdata[NC];

  typedef struct packed {
    int          cyc;
    int          sig;
    logic [31:0] val;
  } lit_t;
  lit_t lits[$];

  int cyc = 0;
  int cur;
  int last_gnt;
  int end_cyc = 0;
  int n_vec = 0;
  int n_fail = 0;

  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- plan model ----------------
  function automatic bit illegal(logic [1:0] mas, logic [31:0] addr);
    if (mas == 2'b11) return 1'b1;
    return (addr % (32'd1 << mas)) != 0;
  endfunction

  task automatic drive(int port, int from, int to, bit rw, logic [1:0] mas,
                       logic [31:0] addr, logic [31:0] wdata);
    for (int i = from; i <= to; i++) begin
      if (port == P_F) begin
        s_freq[i] = 1'b1; s_faddr[i] = addr;
      end else begin
        s_dreq[i] = 1'b1; s_drw[i] = rw; s_dmas[i] = mas;
        s_daddr[i] = addr; s_dwdata[i] = wdata;
      end
    end
  endtask

  task automatic exp_cmd(int from, int to, bit rw, logic [1:0] mas,
                         logic [31:0] addr, logic [31:0] wdata);
    for (int i = from; i <= to; i++) begin
      x_mfa[i] = 1'b1; x_cmd[i] = 1'b1; x_rw[i] = rw; x_mas[i] = mas;
      x_addr[i] = addr; x_wdata[i] = wdata; x_wchk[i] = !rw;
    end
  endtask

  task automatic reset_at(int r);
    s_clr[r] = 1'b0;
    for (int i = r + 1; i < NC; i++) x_rdata[i] = 32'h0;
    last_gnt = P_D;
    cur = r + 1;
  endtask

  // One access granted at cycle cur; memory answers after w WAIT cycles.
  task automatic txn(int port, bit rw, logic [1:0] mas, logic [31:0] addr,
                     logic [31:0] wdata, logic [31:0] mem, int w, int req_from,
                     bit hold, bit junk);
    int c;
    int last;
    c = cur;
    last_gnt = port;
    if (illegal(mas, addr)) begin
      if (port == P_F) x_ferr[c+1] = 1'b1; else x_derr[c+1] = 1'b1;
      last = c + 1;
      cur = c + 2;
    end else begin
      exp_cmd(c + 1, c + w, rw, mas, addr, wdata);
      s_mfc[c+w] = 1'b1;
      s_mrdata[c+w] = mem;
      if (port == P_F) x_fdone[c+w+1] = 1'b1; else x_ddone[c+w+1] = 1'b1;
      if (rw) for (int i = c + w + 1; i < NC; i++) x_rdata[i] = mem;
      if (junk) begin
        s_mfc[c] = 1'b1;
        s_mfc[c+w+1] = 1'b1;
      end
      last = c + w + 1;
      cur = c + w + 2;
    end
    if (!hold) last = c;
    drive(port, req_from, last, rw, mas, addr, wdata);
  endtask

  // Both ports request in the same cycle; order follows round-robin.
  task automatic tie(logic [31:0] fa, logic [31:0] fmem, int fw, bit drw, logic [1:0] dmas,
                     logic [31:0] da, logic [31:0] dwd, logic [31:0] dmem, int dw);
    int c;
    c = cur;
    if (last_gnt == P_D) begin
      txn(P_F, 1'b1, MAS_WORD, fa, 32'h0, fmem, fw, c, 1'b1, 1'b0);
      txn(P_D, drw, dmas, da, dwd, dmem, dw, c, 1'b1, 1'b0);
    end else begin
      txn(P_D, drw, dmas, da, dwd, dmem, dw, c, 1'b1, 1'b0);
      txn(P_F, 1'b1, MAS_WORD, fa, 32'h0, fmem, fw, c, 1'b1, 1'b0);
    end
  endtask

  // Data read that memory never answers.
  task automatic hang();
    int c;
    c = cur;
    last_gnt = P_D;
`ifdef MEM_TIMEOUT_EN
    exp_cmd(c + 1, c + TO, 1'b1, MAS_WORD, 32'h300, 32'h0);
    x_derr[c+TO+1] = 1'b1;
    drive(P_D, c, c + TO + 1, 1'b1, MAS_WORD, 32'h300, 32'h0);
    lits.push_back('{c + TO + 1, 3, 32'h1});
    lits.push_back('{c + TO + 1, 0, 32'h0});
    cur = c + TO + 2;
`else
    exp_cmd(c + 1, c + 8, 1'b1, MAS_WORD, 32'h300, 32'h0);
    drive(P_D, c, c + 8, 1'b1, MAS_WORD, 32'h300, 32'h0);
    lits.push_back('{c + 8, 0, 32'h1});
    reset_at(c + 8);
`endif
  endtask

  task automatic setup();
    int t;
    for (int i = 0; i < NC; i++) begin
      s_clr[i] = 1'b1; s_freq[i] = 1'b0; s_dreq[i] = 1'b0; s_drw[i] = 1'b0;
      s_mfc[i] = 1'b0; s_dmas[i] = 2'b00; s_faddr[i] = 32'h0; s_daddr[i] = 32'h0;
      s_dwdata[i] = 32'h0; s_mrdata[i] = 32'hBAD0_0000 | i;
      x_mfa[i] = 1'b0; x_fdone[i] = 1'b0; x_ferr[i] = 1'b0; x_ddone[i] = 1'b0;
      x_derr[i] = 1'b0; x_cmd[i] = 1'b0; x_wchk[i] = 1'b0; x_rw[i] = 1'b0;
      x_mas[i] = 2'b00; x_addr[i] = 32'h0; x_wdata[i] = 32'h0; x_rdata[i] = 32'h0;
    end
    s_clr[0] = 1'b0;
    reset_at(1);
    // First tie after reset: fetch, then data.
    t = cur;
    tie(32'h104, 32'h1111_2222, 1, 1'b1, MAS_BYTE, 32'h83, 32'h0, 32'h0000_00AB, 2);
    lits.push_back('{t + 2, 1, 32'h1});
    lits.push_back('{t + 6, 2, 32'h1});
    // Fetch word read, memory completes in the third WAIT cycle.
    t = cur;
    txn(P_F, 1'b1, MAS_WORD, 32'h100, 32'h0, 32'hE3A0_0001, 3, t, 1'b1, 1'b0);
    lits.push_back('{t + 1, 0, 32'h1});
    lits.push_back('{t + 3, 0, 32'h1});
    lits.push_back('{t + 4, 1, 32'h1});
    lits.push_back('{t + 4, 4, 32'hE3A0_0001});
    // Misaligned halfword write.
    t = cur;
    txn(P_D, 1'b0, MAS_HALF, 32'h203, 32'h5555_5555, 32'h0, 1, t, 1'b1, 1'b0);
    lits.push_back('{t + 1, 3, 32'h1});
    // Word write, with stray m_mfc in the IDLE and DONE cycles.
    t = cur;
    txn(P_D, 1'b0, MAS_WORD, 32'h40, 32'hDEAD_BEEF, 32'hC0DE_0000, 2, t, 1'b1, 1'b1);
    lits.push_back('{t + 1, 5, 32'h40});
    lits.push_back('{t + 1, 6, 32'hDEAD_BEEF});
    lits.push_back('{t + 3, 2, 32'h1});
    lits.push_back('{t + 3, 4, 32'hE3A0_0001});
    // Illegal size, then misaligned fetch.
    txn(P_D, 1'b1, 2'b11, 32'h0, 32'h0, 32'h0, 1, cur, 1'b1, 1'b0);
    txn(P_F, 1'b1, MAS_WORD, 32'h102, 32'h0, 32'h0, 1, cur, 1'b1, 1'b0);
    // Tie with fetch granted last: data goes first.
    t = cur;
    tie(32'h108, 32'h2222_3333, 2, 1'b0, MAS_HALF, 32'h12, 32'h0000_7777, 32'h0, 1);
    lits.push_back('{t + 2, 2, 32'h1});
    // Request dropped right after the grant cycle still completes.
    txn(P_D, 1'b1, MAS_HALF, 32'h22, 32'h0, 32'h0000_BEEF, 2, cur, 1'b0, 1'b0);
    // Memory answers exactly at the timeout boundary.
    txn(P_F, 1'b1, MAS_WORD, 32'h10C, 32'h0, 32'h4444_5555, TO, cur, 1'b1, 1'b0);
    hang();
    // Reset in the second WAIT cycle of a fetch; the next tie must favour fetch.
    t = cur;
    last_gnt = P_F;
    exp_cmd(t + 1, t + 2, 1'b1, MAS_WORD, 32'h500, 32'h0);
    drive(P_F, t, t + 2, 1'b1, MAS_WORD, 32'h500, 32'h0);
    reset_at(t + 2);
    lits.push_back('{t + 3, 0, 32'h0});
    lits.push_back('{t + 5, 1, 32'h1});
    tie(32'h600, 32'h6666_7777, 1, 1'b1, MAS_WORD, 32'h700, 32'h0, 32'h7777_8888, 1);
    end_cyc = cur + 2;
  endtask

  task automatic apply(int n);
    clr = s_clr[n]; f_req = s_freq[n]; f_addr = s_faddr[n];
    d_req = s_dreq[n]; d_rw = s_drw[n]; d_mas = s_dmas[n];
    d_addr = s_daddr[n]; d_wdata = s_dwdata[n];
    m_mfc = s_mfc[n]; m_rdata = s_mrdata[n];
  endtask

  // ---------------- checking ----------------
  task automatic check(string name, int c, logic [31:0] got, logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s cycle=%0d got=%h expected=%h", name, c, got, exp);
    end
  endtask

  function automatic logic [31:0] sig_val(int s);
    case (s)
      0:       return {31'h0, m_mfa};
      1:       return {31'h0, f_done};
      2:       return {31'h0, d_done};
      3:       return {31'h0, d_err};
      4:       return rdata;
      5:       return m_addr;
      default: return m_wdata;
    endcase
  endfunction

  always @(negedge clk) begin
    if (cyc >= 1 && cyc <= end_cyc) begin
      check("m_mfa",  cyc, {31'h0, m_mfa},  {31'h0, x_mfa[cyc]});
      check("f_done", cyc, {31'h0, f_done}, {31'h0, x_fdone[cyc]});
      check("f_err",  cyc, {31'h0, f_err},  {31'h0, x_ferr[cyc]});
      check("d_done", cyc, {31'h0, d_done}, {31'h0, x_ddone[cyc]});
      check("d_err",  cyc, {31'h0, d_err},  {31'h0, x_derr[cyc]});
      check("rdata",  cyc, rdata, x_rdata[cyc]);
      if (x_cmd[cyc]) begin
        check("m_addr", cyc, m_addr, x_addr[cyc]);
        check("m_rw",   cyc, {31'h0, m_rw}, {31'h0, x_rw[cyc]});
        check("m_mas",  cyc, {30'h0, m_mas}, {30'h0, x_mas[cyc]});
        if (x_wchk[cyc]) check("m_wdata", cyc, m_wdata, x_wdata[cyc]);
      end
      foreach (lits[k]) begin
        if (lits[k].cyc == cyc) begin
          check($sformatf("literal_sig%0d", lits[k].sig), cyc, sig_val(lits[k].sig), lits[k].val);
        end
      end
    end
  end

  initial begin
    setup();
    for (int n = 0; n <= end_cyc; n++) begin
      apply(n);
      @(negedge clk);
    end
    @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
